pcsel_sequencer: RTL and testbench
==================================

# pcsel_sequencer

Control block that drives the program counter's next-PC select (PCSEL) and load enable every cycle. It arbitrates between sequential fetch, taken branch, jump, illegal-op trap, interrupt and reset. It also sequences the boot hold, fetch-wait stalls, trap flush bubbles and fetch-timeout faults. It sits between instruction decode / instruction memory and the PC register.

## Interface
- RST_CYCLES, default 2: cycles PCSEL is held at reset-vector after RESET falls.
- FETCH_TIMEOUT, default 15: max consecutive cycles without INSTR_VALID before a fetch fault; 0 disables the timeout.
- clk  in  1  global clock.
- RESET  in  1  synchronous, active-high reset.
- INSTR_VALID  in  1  fetched instruction and decode flags below are valid this cycle.
- IS_BRANCH  in  1  decoded conditional branch.
- BR_TAKEN  in  1  branch condition true; qualifies IS_BRANCH.
- IS_JUMP  in  1  decoded register-indirect jump.
- ILL_OP  in  1  decoded illegal opcode.
- IRQ  in  1  external interrupt request, level, already synchronous to clk.
- PC_MSB  in  1  current PC bit 31 (1 = supervisor mode).
- PCSEL  out  3  next-PC select. 000 = PC+4, 001 = branch target, 010 = jump target, 011 = illegal-op vector, 100 = interrupt vector, 101 = reset vector.
- PC_EN  out  1  PC loads the selected value at the next clk edge.
- XP_WE  out  1  write PC+4 into the exception-pointer register this cycle.
- IRQ_ACK  out  1  one-cycle pulse when an interrupt is taken.
- FAULT  out  1  sticky; set on fetch timeout, cleared only by RESET.

## Operation
- States: BOOT, RUN, WAIT, FLUSH.
- BOOT: PCSEL=101, PC_EN=1. Counts RST_CYCLES cycles, then moves to RUN.
- RUN, INSTR_VALID=1: a Mealy decision this cycle, with PC_EN=1. Priority, highest first:
  - ILL_OP → 011, XP_WE=1, go to FLUSH.
  - pending IRQ and PC_MSB=0 → 100, XP_WE=1, clear pending, go to FLUSH.
  - IS_JUMP → 010.
  - IS_BRANCH & BR_TAKEN → 001.
  - otherwise → 000.
- RUN, INSTR_VALID=0: PC_EN=0, PCSEL=000, go to WAIT, timeout counter ← 1.
- WAIT: PC_EN=0.
  - INSTR_VALID=1 → decide exactly as in RUN in the same cycle and clear the counter.
  - Counter reaching FETCH_TIMEOUT → PCSEL=011, PC_EN=1, XP_WE=1, set FAULT, go to FLUSH.
- FLUSH: one bubble cycle. PC_EN=0, PCSEL=000, decode inputs ignored. IRQ_ACK=1 if the trap was an interrupt. Then go to RUN.
- Pending IRQ:
  - Set on any cycle with IRQ=1.
  - Cleared when taken or on RESET.
  - Retained while masked by PC_MSB=1 or during WAIT, FLUSH and BOOT.
- ILL_OP in supervisor mode still traps.
- Simultaneous ILL_OP and IRQ: the illegal-op trap is taken and the IRQ stays pending.
- Decode flags with INSTR_VALID=0 are ignored.
- Timeout counter width is $clog2(FETCH_TIMEOUT+1); the counter saturates and never wraps.

## Timing
- Reset values: state=BOOT, PCSEL=101, PC_EN=1, XP_WE=0, IRQ_ACK=0, FAULT=0, counters=0, pending=0.
- RESET asserted mid-operation (any state) takes effect at the next edge. It overrides every in-flight trap or flush.
- Redirect latency: 0 cycles. PCSEL/PC_EN are valid in the same cycle as INSTR_VALID; the PC updates at the following edge.
- Trap costs exactly 2 cycles: the redirect cycle plus the FLUSH cycle.
- An IRQ rising on cycle N is eligible from cycle N+1 (pending is registered).
- RST_CYCLES=0 behaves as 1: BOOT always lasts at least one cycle.

## Configuration
- PCSEQ_IRQ_EN defined: interrupt pending latch, IRQ_ACK and PCSEL=100 path present.
- PCSEQ_IRQ_EN undefined:
  - IRQ is ignored.
  - IRQ_ACK is tied to 0.
  - PCSEL never takes 100.
  - The pending register is absent.

## Structure
- Shared package: PCSEL encoding constants (PCSEL_INCR, PCSEL_BR, PCSEL_JT, PCSEL_ILLOP, PCSEL_XADR, PCSEL_RST) and the state enum, shared with the PC and decode blocks.
- One sub-module, pcseq_irq_pending: IRQ latch with set, take-clear and RESET. Instantiated only under PCSEQ_IRQ_EN.

## Test plan
- RESET high 3 cycles, RST_CYCLES=2 → PCSEL=101 and PC_EN=1 for 3+2 cycles, then RUN. With INSTR_VALID=1 and no flags → PCSEL=000.
- INSTR_VALID=1, IS_BRANCH=1, BR_TAKEN=0, then BR_TAKEN=1, then IS_JUMP=1 → PCSEL 000, 001, 010 on consecutive cycles, PC_EN=1 each.
- ILL_OP=1 and IRQ=1 in the same cycle, PC_MSB=0 → PCSEL=011 and XP_WE=1, FLUSH with IRQ_ACK=0. Next valid instruction → PCSEL=100, XP_WE=1, then FLUSH with IRQ_ACK=1.
- IRQ pulsed one cycle while PC_MSB=1 → no trap. PC_MSB drops to 0 on a later valid cycle → PCSEL=100 on that cycle.
- FETCH_TIMEOUT=15, INSTR_VALID low 15 cycles → PC_EN=0 for 14 cycles, then PCSEL=011, XP_WE=1, FAULT=1. FAULT stays set until RESET.
- RESET asserted during FLUSH → next cycle state BOOT, PCSEL=101, FAULT=0, pending cleared.

Source files
------------

// File: rtl/pcsel_sequencer_pkg.sv
// Shared PCSEL encodings and sequencer state type for the PC, decode and sequencer blocks.
package pcsel_sequencer_pkg;

    localparam int unsigned PCSEL_W = 3;

    localparam logic [PCSEL_W-1:0] PCSEL_INCR  = 3'b000;
    localparam logic [PCSEL_W-1:0] PCSEL_BR    = 3'b001;
    localparam logic [PCSEL_W-1:0] PCSEL_JT    = 3'b010;
    localparam logic [PCSEL_W-1:0] PCSEL_ILLOP = 3'b011;
    localparam logic [PCSEL_W-1:0] PCSEL_XADR  = 3'b100;
    localparam logic [PCSEL_W-1:0] PCSEL_RST   = 3'b101;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_FLUSH = 2'd3
    } pcseq_state_e;

    // A zero count still needs one cycle of activity.
    function automatic int unsigned at_least_one(input int unsigned n);
        return (n == 0) ? 1 : n;
    endfunction

endpackage

// File: rtl/pcsel_sequencer_if.sv
// Decode/fetch-to-sequencer bundle; master is the decode side, slave is the sequencer.
interface pcsel_sequencer_if;
    import pcsel_sequencer_pkg::*;

    logic               INSTR_VALID;
    logic               IS_BRANCH;
    logic               BR_TAKEN;
    logic               IS_JUMP;
    logic               ILL_OP;
    logic               IRQ;
    logic               PC_MSB;
    logic [PCSEL_W-1:0] PCSEL;
    logic               PC_EN;
    logic               XP_WE;
    logic               IRQ_ACK;
    logic               FAULT;

    modport master (
        output INSTR_VALID, IS_BRANCH, BR_TAKEN, IS_JUMP, ILL_OP, IRQ, PC_MSB,
        input  PCSEL, PC_EN, XP_WE, IRQ_ACK, FAULT
    );

    modport slave (
        input  INSTR_VALID, IS_BRANCH, BR_TAKEN, IS_JUMP, ILL_OP, IRQ, PC_MSB,
        output PCSEL, PC_EN, XP_WE, IRQ_ACK, FAULT
    );

endinterface

// File: rtl/pcseq_irq_pending.sv
// Interrupt pending latch: set by IRQ, cleared when the interrupt is taken or on reset.
module pcseq_irq_pending (
    input  logic clk,
    input  logic rst,
    input  logic irq,
    input  logic take,
    output logic pending
);

    logic pending_q;
    logic pending_d;

    // A new request in the take cycle wins so it is not lost.
    always_comb begin
        pending_d = pending_q;
        if (take) pending_d = 1'b0;
        if (irq)  pending_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) pending_q <= 1'b0;
        else     pending_q <= pending_d;
    end

    assign pending = pending_q;

endmodule

// File: rtl/pcsel_sequencer.sv
// Next-PC select / PC load sequencer: boot hold, redirect priority, fetch-wait timeout, trap flush.
// Interrupt support is built only when PCSEQ_IRQ_EN is defined.
module pcsel_sequencer
    import pcsel_sequencer_pkg::*;
#(
    parameter int unsigned RST_CYCLES    = 2,
    parameter int unsigned FETCH_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               RESET,
    pcsel_sequencer_if.slave   bus
);

    localparam int unsigned BOOT_N = at_least_one(RST_CYCLES);
    localparam int unsigned BOOT_W = $clog2(BOOT_N + 1);
    localparam int unsigned TO_W   = (FETCH_TIMEOUT == 0) ? 1 : $clog2(FETCH_TIMEOUT + 1);

    pcseq_state_e       state_q, state_d;
    logic [BOOT_W-1:0]  boot_cnt_q, boot_cnt_d;
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic               fault_q, fault_d;
    logic               irq_trap_q, irq_trap_d;
    logic               irq_pend;
    logic               irq_take_c;
    logic               decide_c;
    logic               boot_last_c;
    logic               timeout_c;
    logic [TO_W-1:0]    to_sat_c;
    logic [31:0]        to_inc_c;
    logic [PCSEL_W-1:0] pcsel_c;
    logic               pc_en_c;
    logic               xp_we_c;
    logic               ack_c;

    assign boot_last_c = (32'(boot_cnt_q) + 32'd1) >= BOOT_N;
    assign to_inc_c    = 32'(to_cnt_q) + 32'd1;
    assign to_sat_c    = (&to_cnt_q) ? to_cnt_q : to_cnt_q + TO_W'(1);
    assign timeout_c   = (FETCH_TIMEOUT != 0) && (to_inc_c >= FETCH_TIMEOUT);

    always_comb begin
        state_d    = state_q;
        boot_cnt_d = boot_cnt_q;
        to_cnt_d   = to_cnt_q;
        fault_d    = fault_q;
        irq_trap_d = irq_trap_q;
        pcsel_c    = PCSEL_INCR;
        pc_en_c    = 1'b0;
        xp_we_c    = 1'b0;
        ack_c      = 1'b0;
        irq_take_c = 1'b0;
        decide_c   = 1'b0;

        case (state_q)
            ST_BOOT: begin
                pcsel_c = PCSEL_RST;
                pc_en_c = 1'b1;
                if (boot_last_c) begin
                    boot_cnt_d = '0;
                    state_d    = ST_RUN;
                end else begin
                    boot_cnt_d = boot_cnt_q + BOOT_W'(1);
                end
            end
            ST_RUN: begin
                if (bus.INSTR_VALID) begin
                    decide_c = 1'b1;
                end else begin
                    to_cnt_d = TO_W'(1);
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.INSTR_VALID) begin
                    decide_c = 1'b1;
                    to_cnt_d = '0;
                end else if (timeout_c) begin
                    pcsel_c    = PCSEL_ILLOP;
                    pc_en_c    = 1'b1;
                    xp_we_c    = 1'b1;
                    fault_d    = 1'b1;
                    irq_trap_d = 1'b0;
                    state_d    = ST_FLUSH;
                end else begin
                    to_cnt_d = to_sat_c;
                end
            end
            ST_FLUSH: begin
                ack_c   = irq_trap_q;
                state_d = ST_RUN;
            end
            default: state_d = ST_BOOT;
        endcase

        // Same-cycle redirect decision shared by RUN and a WAIT that sees a valid fetch.
        if (decide_c) begin
            pc_en_c = 1'b1;
            state_d = ST_RUN;
            if (bus.ILL_OP) begin
                pcsel_c    = PCSEL_ILLOP;
                xp_we_c    = 1'b1;
                irq_trap_d = 1'b0;
                state_d    = ST_FLUSH;
            end else if (irq_pend && !bus.PC_MSB) begin
                pcsel_c    = PCSEL_XADR;
                xp_we_c    = 1'b1;
                irq_take_c = 1'b1;
                irq_trap_d = 1'b1;
                state_d    = ST_FLUSH;
            end else if (bus.IS_JUMP) begin
                pcsel_c = PCSEL_JT;
            end else if (bus.IS_BRANCH && bus.BR_TAKEN) begin
                pcsel_c = PCSEL_BR;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            state_q    <= ST_BOOT;
            boot_cnt_q <= '0;
            to_cnt_q   <= '0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            boot_cnt_q <= boot_cnt_d;
            to_cnt_q   <= to_cnt_d;
            fault_q    <= fault_d;
        end
    end

`ifdef PCSEQ_IRQ_EN
    pcseq_irq_pending u_irq_pending (
        .clk     (clk),
        .rst     (RESET),
        .irq     (bus.IRQ),
        .take    (irq_take_c),
        .pending (irq_pend)
    );

    always_ff @(posedge clk) begin
        if (RESET) irq_trap_q <= 1'b0;
        else       irq_trap_q <= irq_trap_d;
    end

    assign bus.IRQ_ACK = ack_c;
`else
    logic unused_irq;

    assign irq_pend    = 1'b0;
    assign irq_trap_q  = 1'b0;
    assign unused_irq  = ^{bus.IRQ, irq_take_c, irq_trap_d, ack_c};
    assign bus.IRQ_ACK = 1'b0;
`endif

    assign bus.PCSEL = pcsel_c;
    assign bus.PC_EN = pc_en_c;
    assign bus.XP_WE = xp_we_c;
    assign bus.FAULT = fault_q;

endmodule

// File: tb/tb_pcsel_sequencer.sv
// Self-checking bench for pcsel_sequencer: behavioural reference model plus directed literal checks.
module tb_pcsel_sequencer;

`ifdef PCSEQ_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif
    localparam int RST_N = 2;
    localparam int FT    = 15;

    logic clk = 1'b0;
    logic RESET;

    pcsel_sequencer_if bus ();

    pcsel_sequencer #(
        .RST_CYCLES    (RST_N),
        .FETCH_TIMEOUT (FT)
    ) dut (
        .clk   (clk),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference model: cycles left in boot, pending bubble, consecutive missed fetches.
    bit ref_ok = 1'b0;
    int boot_left = 0;
    bit bubble = 1'b0;
    bit bubble_irq = 1'b0;
    bit pend = 1'b0;
    bit fault = 1'b0;
    int miss = 0;

    function automatic int boot_len();
        return (RST_N == 0) ? 1 : RST_N;
    endfunction

    function automatic void predict(output int sel, output bit en, output bit xp, output bit ack,
                                    output bit trap, output bit take, output bit tmo);
        sel = 0; en = 0; xp = 0; ack = 0; trap = 0; take = 0; tmo = 0;
        if (boot_left > 0) begin
            sel = 5; en = 1;
        end else if (bubble) begin
            ack = bubble_irq;
        end else if (bus.INSTR_VALID) begin
            en = 1;
            if (bus.ILL_OP) begin
                sel = 3; xp = 1; trap = 1;
            end else if (IRQ_EN && pend && !bus.PC_MSB) begin
                sel = 4; xp = 1; trap = 1; take = 1;
            end else if (bus.IS_JUMP) begin
                sel = 2;
            end else if (bus.IS_BRANCH && bus.BR_TAKEN) begin
                sel = 1;
            end
        end else if (FT != 0 && miss + 1 >= ((FT < 2) ? 2 : FT)) begin
            sel = 3; en = 1; xp = 1; trap = 1; tmo = 1;
        end
    endfunction

    always @(posedge clk) begin
        int s; bit e, x, a, tr, tk, tm;
        if (RESET) begin
            ref_ok = 1'b1;
            boot_left = boot_len();
            bubble = 0; bubble_irq = 0; pend = 0; fault = 0; miss = 0;
        end else if (ref_ok) begin
            predict(s, e, x, a, tr, tk, tm);
            if (boot_left > 0) begin
                boot_left--;
            end else if (bubble) begin
                bubble = 0;
            end else begin
                miss = bus.INSTR_VALID ? 0 : miss + 1;
                if (tr) begin
                    bubble = 1; bubble_irq = tk; miss = 0;
                end
                if (tm) fault = 1;
            end
            if (IRQ_EN) pend = (pend && !tk) || bus.IRQ;
        end
    end

    always @(negedge clk) begin
        int s; bit e, x, a, tr, tk, tm;
        if (ref_ok) begin
            predict(s, e, x, a, tr, tk, tm);
            chk("model_pcsel",   int'(bus.PCSEL),   s);
            chk("model_pc_en",   int'(bus.PC_EN),   int'(e));
            chk("model_xp_we",   int'(bus.XP_WE),   int'(x));
            chk("model_irq_ack", int'(bus.IRQ_ACK), int'(a));
            chk("model_fault",   int'(bus.FAULT),   int'(fault));
        end
    end

    task automatic drive(input bit v, input bit br, input bit tk, input bit j,
                         input bit ill, input bit irq, input bit msb);
        bus.INSTR_VALID = v;
        bus.IS_BRANCH   = br;
        bus.BR_TAKEN    = tk;
        bus.IS_JUMP     = j;
        bus.ILL_OP      = ill;
        bus.IRQ         = irq;
        bus.PC_MSB      = msb;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        RESET = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (3) tick();

        chk("rst_pcsel", int'(bus.PCSEL), 5);
        chk("rst_pc_en", int'(bus.PC_EN), 1);
        chk("rst_xp_we", int'(bus.XP_WE), 0);
        chk("rst_ack",   int'(bus.IRQ_ACK), 0);
        chk("rst_fault", int'(bus.FAULT), 0);
        RESET = 1'b0;
        drive(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            chk("boot_pcsel", int'(bus.PCSEL), 5);
            chk("boot_pc_en", int'(bus.PC_EN), 1);
            tick();
        end

        drive(1, 0, 0, 0, 0, 0, 0);
        chk("run_incr", int'(bus.PCSEL), 0);
        chk("run_en",   int'(bus.PC_EN), 1);
        tick();
        drive(1, 1, 0, 0, 0, 0, 0);
        chk("br_not_taken", int'(bus.PCSEL), 0);
        tick();
        drive(1, 1, 1, 0, 0, 0, 0);
        chk("br_taken", int'(bus.PCSEL), 1);
        chk("br_en",    int'(bus.PC_EN), 1);
        tick();
        drive(1, 0, 0, 1, 0, 0, 0);
        chk("jump", int'(bus.PCSEL), 2);
        tick();
        drive(0, 1, 1, 1, 1, 0, 0);
        chk("invalid_ignored_sel", int'(bus.PCSEL), 0);
        chk("invalid_ignored_en",  int'(bus.PC_EN), 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(1, 0, 0, 1, 0, 0, 0);
        chk("wait_resume_jump", int'(bus.PCSEL), 2);
        chk("wait_resume_en",   int'(bus.PC_EN), 1);
        tick();

        drive(1, 0, 0, 0, 1, 1, 0);
        chk("ill_irq_sel", int'(bus.PCSEL), 3);
        chk("ill_irq_xp",  int'(bus.XP_WE), 1);
        tick();
        drive(1, 0, 0, 1, 0, 0, 0);
        chk("flush1_en",  int'(bus.PC_EN), 0);
        chk("flush1_ack", int'(bus.IRQ_ACK), 0);
        tick();
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("irq_take_sel", int'(bus.PCSEL), IRQ_EN ? 4 : 0);
        chk("irq_take_xp",  int'(bus.XP_WE), IRQ_EN ? 1 : 0);
        tick();
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("flush2_ack", int'(bus.IRQ_ACK), IRQ_EN ? 1 : 0);
        tick();

        drive(1, 0, 0, 0, 0, 1, 1);
        chk("irq_masked_0", int'(bus.PCSEL), 0);
        tick();
        drive(1, 0, 0, 1, 0, 0, 1);
        chk("irq_masked_jump", int'(bus.PCSEL), 2);
        tick();
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("irq_unmasked", int'(bus.PCSEL), IRQ_EN ? 4 : 0);
        tick();
        drive(1, 0, 0, 0, 0, 0, 0);
        tick();

        for (int i = 0; i < 15; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0);
            if (i < 14) begin
                chk("to_wait_en", int'(bus.PC_EN), 0);
            end else begin
                chk("to_sel", int'(bus.PCSEL), 3);
                chk("to_en",  int'(bus.PC_EN), 1);
                chk("to_xp",  int'(bus.XP_WE), 1);
            end
            tick();
        end
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("to_fault_set", int'(bus.FAULT), 1);
        chk("to_flush_en",  int'(bus.PC_EN), 0);
        tick();
        repeat (3) begin
            drive(1, 1, 1, 0, 0, 0, 0);
            chk("fault_sticky", int'(bus.FAULT), 1);
            tick();
        end

        drive(1, 0, 0, 0, 0, 1, 1);
        tick();
        drive(1, 0, 0, 0, 1, 0, 1);
        chk("ill_super_sel", int'(bus.PCSEL), 3);
        tick();
        RESET = 1'b1;
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("flush_before_rst_en", int'(bus.PC_EN), 0);
        tick();
        RESET = 1'b0;
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("rst_flush_sel",   int'(bus.PCSEL), 5);
        chk("rst_flush_fault", int'(bus.FAULT), 0);
        repeat (2) tick();
        drive(1, 0, 0, 0, 0, 0, 0);
        chk("pend_cleared", int'(bus.PCSEL), 0);
        chk("pend_cleared_xp", int'(bus.XP_WE), 0);
        tick();
        drive(1, 0, 0, 0, 0, 0, 0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
